// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA frame-buffer prefetch reader.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FILL   = 2'd2,
    ST_STREAM = 2'd3
  } vga_rd_state_t;

  // 640x480 pixels at one 8-byte stride per pixel.
  localparam int unsigned FRAME_BYTES_640x480 = 32'h0025_8000;
  localparam int unsigned STRIDE_DEFAULT      = 8;

endpackage

// File: rtl/pixel_fifo_sync.sv
// Single-clock circular pixel buffer with occupancy count and synchronous clear.
module pixel_fifo_sync #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clr,
  input  logic                    i_wr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic                    i_rd,
  output logic [DATA_W-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = i_rd && (r_level != '0);
  // A full buffer only accepts a write when a pop frees the slot the same cycle.
  assign w_push = i_wr && ((r_level != LVL_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;

  // Credit accounting upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (reset)
    !(i_wr && !i_clr && !w_pop && (r_level == LVL_W'(DEPTH))));

endmodule

// File: rtl/vga_prefetch_reader.sv
// Frame-buffer prefetch reader: credit-limited pipelined Avalon reads into a pixel FIFO.
module vga_prefetch_reader
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W          = 26,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEPTH           = 32,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned STRIDE          = STRIDE_DEFAULT,
  parameter int unsigned FRAME_BYTES     = FRAME_BYTES_640x480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ADDR_W-1:0]       base,
  input  logic                    frame_start,
  output logic [ADDR_W-1:0]       master_address,
  output logic                    master_read,
  input  logic                    master_waitrequest,
  input  logic [DATA_W-1:0]       master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    pixel_read,
  output logic [DATA_W-1:0]       pixel_data,
  output logic                    pixel_valid,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             underflow_count
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  vga_rd_state_t     r_state;
  vga_rd_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_base_pend;
  logic [ADDR_W-1:0] r_base_q;
  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_addr;
  logic              r_read;
  logic [OUT_W-1:0]  r_out;
  logic [DATA_W-1:0] r_pix_data;
  logic              r_pix_valid;
  logic [15:0]       r_underflow;

  logic [LVL_W-1:0]  w_level;
  logic [DATA_W-1:0] w_head;
  logic              w_active;
  logic              w_accept;
  logic              w_ret;
  logic              w_push;
  logic              w_pop;
  logic              w_clr;
  logic              w_flush_exit;
  logic              w_issue;
  logic [31:0]       w_credit;
  logic [ADDR_W-1:0] w_off_sum;
  logic [ADDR_W-1:0] w_off_adv;
  logic [ADDR_W-1:0] w_off_nxt;
  logic [ADDR_W-1:0] w_base_nxt;

  assign w_active = (r_state == ST_FILL) || (r_state == ST_STREAM);
  assign w_accept = r_read && !master_waitrequest;
  // Returns only count against live credits; strays after reset are ignored.
  assign w_ret    = master_readdatavalid && (r_state != ST_IDLE) && (r_out != '0);
  assign w_push   = w_ret && w_active;
  assign w_pop    = pixel_read && (w_level != '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_exit = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_clr = 1'b1;
        // A held request must complete first so its word is drained here.
        if (!frame_start && (r_out == '0) && !r_read) begin
          w_state_nxt  = ST_FILL;
          w_flush_exit = 1'b1;
        end
      end
      ST_FILL: begin
        if (frame_start)                        w_state_nxt = ST_FLUSH;
        else if (w_level >= LVL_W'(DEPTH / 2))  w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (frame_start) w_state_nxt = ST_FLUSH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (frame_start) w_clr = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Counting the in-flight accept keeps level+outstanding within DEPTH.
  assign w_credit = 32'(w_level) + 32'(r_out) + 32'(w_accept);
  assign w_issue  = w_active && !frame_start && enable &&
                    (w_credit < DEPTH) &&
                    ((32'(r_out) + 32'(w_accept)) < MAX_OUTSTANDING);

  assign w_off_sum  = r_offset + ADDR_W'(STRIDE);
  assign w_off_adv  = (w_off_sum == ADDR_W'(FRAME_BYTES)) ? '0 : w_off_sum;
  assign w_off_nxt  = w_flush_exit ? '0 : (w_accept ? w_off_adv : r_offset);
  assign w_base_nxt = w_flush_exit ? r_base_pend : r_base_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base_pend <= '0;
      r_base_q    <= '0;
      r_offset    <= '0;
      r_addr      <= '0;
      r_read      <= 1'b0;
      r_out       <= '0;
    end else begin
      if (frame_start) r_base_pend <= base;
      r_base_q <= w_base_nxt;
      r_offset <= w_off_nxt;
      r_out    <= r_out + OUT_W'(w_accept) - OUT_W'(w_ret);
      if (!(r_read && master_waitrequest)) begin
        r_read <= w_issue;
        r_addr <= w_base_nxt + w_off_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_underflow <= '0;
    end else begin
      r_pix_valid <= w_pop;
      if (w_pop) begin
        r_pix_data <= w_head;
      end else if (pixel_read && (r_underflow != 16'hFFFF)) begin
        r_underflow <= r_underflow + 16'd1;
      end
    end
  end

  pixel_fifo_sync #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_wr    (w_push),
    .i_wdata (master_readdata),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_level (w_level)
  );

  assign master_address  = r_addr;
  assign master_read     = r_read;
  assign pixel_data      = r_pix_data;
  assign pixel_valid     = r_pix_valid;
  assign level           = w_level;
  assign underflow_count = r_underflow;

endmodule

// File: tb/tb_vga_prefetch_reader.sv
// Directed bench for vga_prefetch_reader with a latency-programmable Avalon slave model.
module tb_vga_prefetch_reader;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [25:0] base = '0;
  logic        frame_start = 1'b0;
  logic [25:0] master_address;
  logic        master_read;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        pixel_read = 1'b0;
  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic [5:0]  level;
  logic [15:0] underflow_count;

  vga_prefetch_reader #(
    .FRAME_BYTES (32'h180)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .base                 (base),
    .frame_start          (frame_start),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .pixel_read           (pixel_read),
    .pixel_data           (pixel_data),
    .pixel_valid          (pixel_valid),
    .level                (level),
    .underflow_count      (underflow_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Slave model: decisions made on the falling edge for the following rising edge.
  typedef struct {
    logic [25:0] addr;
    int unsigned due;
  } rd_t;

  rd_t         q[$];
  logic [25:0] acc_log[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned acc_count = 0;
  int unsigned stall_idx = 0;
  int unsigned stall_left = 0;
  int unsigned stall_seen = 0;
  bit          stall_active = 1'b0;

  always @(negedge clk) begin
    rd_t r;
    cyc++;
    if ((stall_left > 0) && (stall_active || (master_read && (acc_count == stall_idx)))) begin
      stall_active = 1'b1;
      stall_seen++;
      check("stall_read", 32'(master_read), 32'h1);
      check("stall_addr", 32'(master_address), 32'h100010);
      stall_left--;
      master_waitrequest = 1'b1;
    end else begin
      stall_active = 1'b0;
      master_waitrequest = 1'b0;
      if (master_read && !reset) begin
        q.push_back('{addr: master_address, due: cyc + lat});
        acc_log.push_back(master_address);
        acc_count++;
      end
    end
    if ((q.size() > 0) && (q[0].due <= cyc)) begin
      r = q.pop_front();
      master_readdatavalid = 1'b1;
      master_readdata = 32'hA000_0000 | 32'(r.addr);
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata = '0;
    end
  end

  logic [31:0] popped[$];
  int unsigned n;
  int unsigned exp_idx;
  int unsigned exp_under;
  bit          first;
  int unsigned max_level;
  bit          any_read;

  initial begin
    // Reset values
    tick();
    check("rst_read", 32'(master_read), 32'h0);
    check("rst_addr", 32'(master_address), 32'h0);
    check("rst_pdata", pixel_data, 32'h0);
    check("rst_pvalid", 32'(pixel_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_under", 32'(underflow_count), 32'h0);
    tick();
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) tick();

    // Frame start, zero-latency slave, fill with no consumer
    base = 26'h100000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while ((acc_log.size() < 2) && (n < 50)) begin tick(); n++; end
    check("t1_acc_timeout", 32'(n < 50), 32'h1);
    check("t1_addr0", 32'(acc_log[0]), 32'h100000);
    check("t1_addr1", 32'(acc_log[1]), 32'h100008);
    n = 0;
    while ((level != 6'd16) && (n < 100)) begin tick(); n++; end
    check("t1_lvl16_timeout", 32'(n < 100), 32'h1);
    tick();
    check("t1_stream", 32'(dut.r_state), 32'(ST_STREAM));
    repeat (60) tick();
    check("t1_level_full", 32'(level), 32'd32);
    check("t1_read_idle", 32'(master_read), 32'h0);
    pixel_read = 1'b1;
    tick();
    pixel_read = 1'b0;
    check("t1_pop0_valid", 32'(pixel_valid), 32'h1);
    check("t1_pop0_data", pixel_data, 32'hA010_0000);
    pixel_read = 1'b1;
    tick();
    pixel_read = 1'b0;
    check("t1_pop1_data", pixel_data, 32'hA010_0008);
    tick();
    check("t1_pop_done", 32'(pixel_valid), 32'h0);
    check("t1_no_under", 32'(underflow_count), 32'h0);
    repeat (10) tick();

    // Waitrequest held for 5 cycles on the third request
    acc_log.delete();
    acc_count = 0;
    stall_idx = 2;
    stall_left = 5;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (60) tick();
    check("t2_stall_cycles", stall_seen, 32'd5);
    check("t2_addr1", 32'(acc_log[1]), 32'h100008);
    check("t2_addr2", 32'(acc_log[2]), 32'h100010);
    check("t2_addr3", 32'(acc_log[3]), 32'h100018);

    // Wrap at FRAME_BYTES (0x180) with ordering across the wrap
    acc_log.delete();
    popped.delete();
    base = 26'h200000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while ((popped.size() < 52) && (n < 400)) begin
      tick();
      n++;
      if (pixel_valid) popped.push_back(pixel_data);
      pixel_read = ~pixel_read;
    end
    pixel_read = 1'b0;
    check("t3_timeout", 32'(n < 400), 32'h1);
    check("t3_acc47", 32'(acc_log[47]), 32'h200178);
    check("t3_acc48", 32'(acc_log[48]), 32'h200000);
    check("t3_pix0", popped[0], 32'hA020_0000);
    check("t3_pix47", popped[47], 32'hA020_0178);
    check("t3_pix48", popped[48], 32'hA020_0000);
    check("t3_pix49", popped[49], 32'hA020_0008);

    // 20-cycle slave, consumer pops every cycle from a clean reset
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    lat = 20;
    base = 26'h300000;
    frame_start = 1'b1;
    pixel_read = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_idx = 0;
    exp_under = 0;
    first = 1'b1;
    n = 0;
    while ((exp_idx < 40) && (n < 600)) begin
      if (pixel_valid) begin
        check("t4_pix", pixel_data, 32'hA030_0000 + 32'(exp_idx * 8));
        if (first) check("t4_under_first", 32'(underflow_count), 32'd24);
        first = 1'b0;
        exp_idx++;
      end else begin
        exp_under++;
      end
      check("t4_under", 32'(underflow_count), exp_under);
      tick();
      n++;
    end
    pixel_read = 1'b0;
    check("t4_count", exp_idx, 32'd40);

    // frame_start with 10 reads in flight
    acc_log.delete();
    base = 26'h380000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while ((acc_log.size() == 0) && (n < 100)) begin tick(); n++; end
    check("t5_start_timeout", 32'(n < 100), 32'h1);
    n = 0;
    while ((q.size() != 10) && (n < 100)) begin tick(); n++; end
    check("t5_ten_timeout", 32'(n < 100), 32'h1);
    acc_log.delete();
    base = 26'h400000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while ((acc_log.size() == 0) && (n < 200)) begin tick(); n++; end
    check("t5_first_timeout", 32'(n < 200), 32'h1);
    check("t5_first_addr", 32'(acc_log[0]), 32'h400000);
    check("t5_level_flushed", 32'(level), 32'h0);
    pixel_read = 1'b1;
    n = 0;
    while (!pixel_valid && (n < 200)) begin tick(); n++; end
    pixel_read = 1'b0;
    check("t5_pix_timeout", 32'(n < 200), 32'h1);
    check("t5_first_pix", pixel_data, 32'hA040_0000);

    // Asynchronous reset mid-stream; late returns must be ignored
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("t6_read", 32'(master_read), 32'h0);
    check("t6_addr", 32'(master_address), 32'h0);
    check("t6_pdata", pixel_data, 32'h0);
    check("t6_pvalid", 32'(pixel_valid), 32'h0);
    check("t6_level", 32'(level), 32'h0);
    check("t6_under", 32'(underflow_count), 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    max_level = 0;
    any_read = 1'b0;
    repeat (40) begin
      tick();
      if (32'(level) > max_level) max_level = 32'(level);
      if (master_read) any_read = 1'b1;
    end
    check("t6_late_level", max_level, 32'h0);
    check("t6_no_read", 32'(any_read), 32'h0);
    check("t6_idle", 32'(dut.r_state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_prefetch_reader.md
# vga_prefetch_reader

Parametrised frame-buffer reader sitting between the SDRAM Avalon-MM port and the VGA scan-out logic. It issues pipelined word reads that walk the frame buffer linearly from a latched base, with wrap at the frame size, and buffers returned pixels in a circular FIFO. It supplies them to the pixel consumer on a one-cycle pop handshake. Compared with the previous single-configuration reader, it adds:
- credit-based flow control;
- a frame-start resynchronisation with in-flight flush;
- an underflow counter;
- fully parametrised width, depth, stride and frame size.

## Interface
Parameters:
- ADDR_W, 26, Avalon byte-address width
- DATA_W, 32, pixel/bus data width
- DEPTH, 32, pixel FIFO entries; power of two, ≥4
- MAX_OUTSTANDING, 16, maximum issued-but-unreturned reads; ≤DEPTH
- STRIDE, 8, byte increment between consecutive pixels
- FRAME_BYTES, 26'h258000, frame size in bytes; multiple of STRIDE

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  allows issuing reads; pops are always serviced
- base  in  ADDR_W  frame-buffer start address, sampled on frame_start
- frame_start  in  1  one-cycle pulse: restart stream at base
- master_address  out  ADDR_W  read address
- master_read  out  1  read request
- master_waitrequest  in  1  slave stall
- master_readdata  in  DATA_W  returned data
- master_readdatavalid  in  1  returned-data strobe, in issue order
- pixel_read  in  1  consumer pop request
- pixel_data  out  DATA_W  popped pixel
- pixel_valid  out  1  pixel_data holds a real pixel this cycle
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- underflow_count  out  16  saturating count of pops while empty

## Operation
- States: IDLE, FLUSH, FILL, STREAM.
- State transitions:
  - IDLE→FLUSH on frame_start.
  - FLUSH→FILL when outstanding==0.
  - FILL→STREAM when level==DEPTH/2.
  - STREAM→FLUSH on frame_start.
  - frame_start in FILL also goes to FLUSH.
- FLUSH actions:
  - no issue; returned data discarded; FIFO pointers cleared.
  - On exit, base_q←base (captured at the frame_start cycle), offset←0.
- Issue condition: state∈{FILL,STREAM} && enable && (level+outstanding)<DEPTH && outstanding<MAX_OUTSTANDING.
- Request acceptance: accepted = master_read && !master_waitrequest.
  - On acceptance: outstanding+1 and offset advances.
  - master_address and master_read hold stable while waitrequest is high.
- Address generation:
  - master_address = base_q + offset.
  - next offset = offset+STRIDE, or 0 when that sum equals FRAME_BYTES (exact compare, no modulo).
  - Sum truncates to ADDR_W.
- Data return: each master_readdatavalid decrements outstanding.
  - In FILL/STREAM the word is written to the FIFO.
  - In FLUSH the word is dropped.
- Pop handling:
  - pixel_read with level>0: pop; pixel_data←head, pixel_valid←1.
  - pixel_read with level==0: pixel_valid←0, underflow_count+1 (saturates at 16'hFFFF). No bypass of same-cycle return data.
- Simultaneous events:
  - Push and pop in the same cycle leave level unchanged.
  - Accept and return in the same cycle leave outstanding unchanged.
  - frame_start during a pop: the pop completes from the old frame.
- Reset outputs: master_read=0, master_address=0, pixel_data=0, pixel_valid=0, level=0, underflow_count=0; state=IDLE.
  - Reset mid-burst abandons outstanding reads.
  - Late readdatavalid after reset in IDLE is ignored.

## Timing
- pixel_valid and pixel_data are registered; they are updated the cycle after pixel_read and valid for one cycle.
- Issue latency: master_read rises the cycle after the issue condition becomes true.
  - Back-to-back accepts are possible, one per cycle.
- Return latency: data written at a returned-word edge is poppable from the next cycle.
- level and outstanding are registered.
  - The credit check uses current register values, so the FIFO can never overflow.
  - Overflow is an assertion failure.
- frame_start to first new-frame request: drain time + 2 cycles.

## Structure
- Package vga_pkg holds:
  - state enum vga_rd_state_t;
  - FRAME_BYTES_640x480 default;
  - STRIDE default.
- One sub-module, pixel_fifo_sync: DEPTH×DATA_W circular buffer with wr/rd/level, built on the same clk and reset.
- The FSM, address generator and credit counter stay in the top level.

## Test plan
- Reset, then frame_start with base=26'h100000 and zero-latency slave:
  - first address is 26'h100000, next 26'h100008;
  - STREAM entered at level=16;
  - level stops at 32 with no pop.
- waitrequest held high 5 cycles on the third request: address 26'h100010 and master_read stay stable all 5 cycles; one accept only.
- Offset reaching FRAME_BYTES-8: next address is base_q (wrap), and data ordering is preserved across the wrap.
- pixel_read on every cycle against a slave with 20-cycle latency:
  - underflow_count increments once per empty pop;
  - pixel_valid=0 on those cycles;
  - no pop is lost once data arrives.
- frame_start with 10 reads outstanding:
  - the 10 returns are discarded;
  - the first post-flush address equals the new base;
  - the first popped pixel equals the new base's data.
- Reset asserted mid-stream: all outputs reach their reset values asynchronously, and late readdatavalid does not change level.
